hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl_pkg.sv | 39 +++
 rtl/hazard_fwd_ctrl_fwd_match.sv | 32 +++
 rtl/hazard_fwd_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// rtl/hazard_fwd_ctrl_pkg.sv - shared constants, FSM states and shadow slot types
// Purpose: forward-select encodings, the zero register index, the controller
//          state enumeration and the EX/MEM/WB shadow slot layouts.
// Ports:   none (package)
package hazard_fwd_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       we;
    logic       mr;
    logic       v;
  } ex_slot_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       we;
    logic       mr;
  } mem_slot_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       we;
  } wb_slot_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// rtl/hazard_fwd_ctrl_fwd_match.sv - one EX operand forward select
// Purpose: picks the forwarding source for a single EX source register.
// Ports:   src_i       EX source register index
//          src_valid_i EX slot holds a live instruction
//          mem_dst_i   MEM slot destination, mem_we_i MEM slot writes
//          wb_dst_i    WB slot destination,  wb_we_i  WB slot writes
//          sel_o       2-bit operand mux select
module fwd_match
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       src_valid_i,
  input  logic [4:0] mem_dst_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_dst_i,
  input  logic       wb_we_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    // MEM is checked first: it holds the younger producer, so it wins.
    if (src_valid_i) begin
      if (mem_we_i && (mem_dst_i != REG_ZERO) && (mem_dst_i == src_i)) begin
        sel_o = FWD_EXMEM;
      end else if (wb_we_i && (wb_dst_i != REG_ZERO) && (wb_dst_i == src_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - pipeline hazard detection and forwarding control
// Purpose: shadows the EX/MEM/WB pipeline slots, detects load-use hazards,
//          handles flush and memory-wait freeze, and drives forward selects.
// Ports:   clk, rst (sync, active-high)
//          id_valid/id_rs/id_rt/id_dst/id_regwrite/id_memread  ID stage info
//          flush     squash ID instruction, mem_busy  freeze pipeline
//          fwd_a/fwd_b  EX operand mux selects
//          stall     hold PC and IF/ID, bubble_ex  NOP into ID/EX
//          freeze    hold all pipeline registers
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_dst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       flush,
  input  logic       mem_busy,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall,
  output logic       bubble_ex,
  output logic       freeze
);

  state_e    state_q, state_d;
  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q, wb_d;

  logic load_use;
  logic run_stall, run_bubble;
  state_e run_next;

  assign load_use = id_valid && ex_q.v && ex_q.we && ex_q.mr &&
                    (ex_q.dst != REG_ZERO) &&
                    ((ex_q.dst == id_rs) || (ex_q.dst == id_rt));

  // Normal (non-frozen) evaluation, shared by RUN, LOAD_STALL and the
  // first idle cycle out of MEM_WAIT. Flush outranks load-use.
  always_comb begin
    run_stall  = 1'b0;
    run_bubble = 1'b0;
    run_next   = ST_RUN;
    if (flush) begin
      run_bubble = 1'b1;
    end else if (load_use) begin
      run_stall  = 1'b1;
      run_bubble = 1'b1;
      run_next   = ST_LOAD_STALL;
    end
  end

  always_comb begin
    state_d   = ST_RUN;
    stall     = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    case (state_q)
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          state_d = ST_MEM_WAIT;
          stall   = 1'b1;
          freeze  = 1'b1;
        end else begin
          state_d   = run_next;
          stall     = run_stall;
          bubble_ex = run_bubble;
        end
      end
      default: begin
        if (mem_busy) begin
          state_d = ST_MEM_WAIT;
          stall   = 1'b1;
          freeze  = 1'b1;
        end else begin
          state_d   = run_next;
          stall     = run_stall;
          bubble_ex = run_bubble;
        end
      end
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_busy) begin
      if (bubble_ex) begin
        ex_d = '0;
      end else begin
        ex_d.rs  = id_rs;
        ex_d.rt  = id_rt;
        ex_d.dst = id_dst;
        ex_d.we  = id_regwrite && id_valid;
        ex_d.mr  = id_memread && id_valid;
        ex_d.v   = id_valid;
      end
      mem_d.dst = ex_q.dst;
      mem_d.we  = ex_q.we;
      mem_d.mr  = ex_q.mr;
      wb_d.dst  = mem_q.dst;
      wb_d.we   = mem_q.we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  fwd_match u_fwd_a (
    .src_i       (ex_q.rs),
    .src_valid_i (ex_q.v),
    .mem_dst_i   (mem_q.dst),
    .mem_we_i    (mem_q.we),
    .wb_dst_i    (wb_q.dst),
    .wb_we_i     (wb_q.we),
    .sel_o       (fwd_a)
  );

  fwd_match u_fwd_b (
    .src_i       (ex_q.rt),
    .src_valid_i (ex_q.v),
    .mem_dst_i   (mem_q.dst),
    .mem_we_i    (mem_q.we),
    .wb_dst_i    (wb_q.dst),
    .wb_we_i     (wb_q.we),
    .sel_o       (fwd_b)
  );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_dst;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic       mem_busy;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
  logic       bubble_ex;
  logic       freeze;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_dst      (id_dst),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .mem_busy    (mem_busy),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .bubble_ex   (bubble_ex),
    .freeze      (freeze)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                         input logic st, input logic bu, input logic fr);
    chk({tag, ".fwd_a"}, fwd_a, fa);
    chk({tag, ".fwd_b"}, fwd_b, fb);
    chk({tag, ".stall"}, {1'b0, stall}, {1'b0, st});
    chk({tag, ".bubble_ex"}, {1'b0, bubble_ex}, {1'b0, bu});
    chk({tag, ".freeze"}, {1'b0, freeze}, {1'b0, fr});
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_busy = 1'b0;
    nop();
    tick(); tick();
    rst = 1'b0; #1;
    chk_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Back-to-back ALU: add $3 ; sub rs=$3
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 0); tick();
    set_id(1, 5'd3, 5'd4, 5'd8, 1, 0); tick();
    nop();
    chk_all("b2b", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    // One gap: add $9 ; or $10 ; use rs=$9
    set_id(1, 5'd1, 5'd2, 5'd9, 1, 0); tick();
    set_id(1, 5'd1, 5'd2, 5'd10, 1, 0); tick();
    set_id(1, 5'd9, 5'd0, 5'd11, 1, 0); tick();
    nop();
    chk_all("gap", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);

    // Load-use: lw $5 ; add rt=$5
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 1); tick();
    set_id(1, 5'd6, 5'd5, 5'd12, 1, 0);
    chk_all("lu_detect", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("lu_stallcyc", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_all("lu_fwd", 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);

    // Double hazard: two writers of $7, then consumer rs=rt=$7
    set_id(1, 5'd1, 5'd2, 5'd7, 1, 0); tick();
    set_id(1, 5'd1, 5'd2, 5'd7, 1, 0); tick();
    set_id(1, 5'd7, 5'd7, 5'd13, 1, 0); tick();
    nop();
    chk_all("double", 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);

    // Zero register: lw $0 then consumer of $0 - no stall, no forward
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 1); tick();
    set_id(1, 5'd0, 5'd0, 5'd14, 1, 0);
    chk_all("zero_id", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_all("zero_ex", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Flush during load-use
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 1); tick();
    set_id(1, 5'd6, 5'd5, 5'd12, 1, 0);
    flush = 1'b1; #1;
    chk_all("flush_lu", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    nop();
    // squashed consumer must not forward from lw $5 now in MEM
    chk_all("flush_next", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Memory wait mid-stream
    set_id(1, 5'd1, 5'd2, 5'd14, 1, 0); tick();
    set_id(1, 5'd14, 5'd0, 5'd15, 1, 0); tick();
    nop();
    chk_all("mw_pre", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    mem_busy = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk_all($sformatf("mw_busy%0d", i), 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
      tick();
    end
    mem_busy = 1'b0; #1;
    chk_all("mw_resume", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    // consumer moved to MEM, add $14 to WB; EX now empty
    chk_all("mw_shift", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset while in MEM_WAIT, with a live forward held in the slots
    set_id(1, 5'd1, 5'd2, 5'd16, 1, 0); tick();
    set_id(1, 5'd16, 5'd16, 5'd17, 1, 0); tick();
    nop();
    mem_busy = 1'b1; tick();
    chk_all("rst_mw_pre", 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
    rst = 1'b1; tick();
    rst = 1'b0; mem_busy = 1'b0; #1;
    chk_all("rst_mw", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset while in LOAD_STALL: consumer held in ID must not stall after
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 1); tick();
    set_id(1, 5'd6, 5'd5, 5'd12, 1, 0);
    chk_all("rst_ls_pre", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk_all("rst_ls", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
